aes_core_arbiter: RTL

- Owns the single shared aes_core in the AES-GCM datapath and schedules three users onto it:
  - key expansion plus H = AES(K, 0^128);
  - tagmask = AES(K, J0), with J0 = {IV, 31'b0, 1'b1};
  - CTR keystream blocks for ctr_xor.
- Drives aes_core init/next/block and tracks which user owns the in-flight operation.
- Routes each result to the correct output, advances ctr_gen, and handles key reloads that arrive mid-operation.

---
 rtl/aes_gcm_pkg.sv | 22 ++
 rtl/aes_core_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_gcm_pkg.sv
// Shared types and constants for the AES-GCM datapath: arbiter FSM state,
// operation owner encoding, block width and the J0 counter suffix.
package aes_gcm_pkg;

    localparam int AES_BLK_W = 128;
    localparam logic [31:0] J0_SUFFIX = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        WAIT
    } state_e;

    typedef enum logic [2:0] {
        NONE,
        KEY,
        H,
        TM,
        CTR
    } owner_e;

endpackage

// File: rtl/aes_core_arbiter.sv
// Schedules key expansion + H, tagmask and CTR keystream onto one aes_core.
// Optional watchdog on the WAIT state is enabled by AES_CORE_ARBITER_WDOG_EN.
module aes_core_arbiter
    import aes_gcm_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_load,
    input  logic                 start,
    input  logic [95:0]          iv,
    input  logic                 ks_req,
    input  logic [AES_BLK_W-1:0] ctr_block,
    input  logic                 aes_ready,
    input  logic [AES_BLK_W-1:0] aes_result,
    output logic                 aes_init,
    output logic                 aes_next,
    output logic [AES_BLK_W-1:0] aes_block,
    output logic                 ctr_next,
    output logic [AES_BLK_W-1:0] h_data,
    output logic                 h_ready,
    output logic [AES_BLK_W-1:0] tagmask_data,
    output logic                 tagmask_valid,
    output logic [AES_BLK_W-1:0] ks_data,
    output logic                 ks_valid,
    output logic                 busy,
    output logic                 wdog_err
);

    // One counter serves the guard window and the WAIT watchdog.
    localparam int unsigned CNT_MAX = (GUARD_CYCLES > TIMEOUT_CYCLES) ? GUARD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    state_e               state, state_d;
    owner_e               owner, issue_own;
    logic                 key_pend, h_pend, tm_pend, ks_pend;
    logic                 stale;
    logic [CNT_W-1:0]     cnt;
    logic [AES_BLK_W-1:0] j0;
    logic                 complete, discard;

`ifdef AES_CORE_ARBITER_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic wdog_fire;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_d   = state;
        issue_own = NONE;
        complete  = 1'b0;
        discard   = 1'b0;
`ifdef AES_CORE_ARBITER_WDOG_EN
        wdog_fire = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (aes_ready) begin
                    if (key_pend)               issue_own = KEY;
                    else if (h_pend)            issue_own = H;
                    else if (h_ready && tm_pend) issue_own = TM;
                    else if (h_ready && ks_pend) issue_own = CTR;
                    if (issue_own != NONE) state_d = GUARD;
                end
            end
            GUARD: begin
                if (cnt == GUARD_LAST) state_d = WAIT;
            end
            WAIT: begin
                if (aes_ready) begin
                    complete = 1'b1;
                    // A result computed under an old key or an old J0 is never delivered.
                    discard  = stale || key_load || (start && owner == TM);
                    state_d  = IDLE;
                end
`ifdef AES_CORE_ARBITER_WDOG_EN
                else if (cnt == WDOG_LAST) begin
                    wdog_fire = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= NONE;
            key_pend      <= 1'b0;
            h_pend        <= 1'b0;
            tm_pend       <= 1'b0;
            ks_pend       <= 1'b0;
            stale         <= 1'b0;
            cnt           <= '0;
            j0            <= '0;
            aes_init      <= 1'b0;
            aes_next      <= 1'b0;
            aes_block     <= '0;
            ctr_next      <= 1'b0;
            h_data        <= '0;
            h_ready       <= 1'b0;
            tagmask_data  <= '0;
            tagmask_valid <= 1'b0;
            ks_data       <= '0;
            ks_valid      <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= (state_d != state) ? '0 : cnt + 1'b1;
            aes_init <= 1'b0;
            aes_next <= 1'b0;
            ctr_next <= 1'b0;
            ks_valid <= 1'b0;

            if (state == IDLE && issue_own != NONE) begin
                owner <= issue_own;
                stale <= key_load || (start && issue_own == TM);
                case (issue_own)
                    KEY: aes_init <= 1'b1;
                    H: begin
                        aes_block <= '0;
                        aes_next  <= 1'b1;
                    end
                    TM: begin
                        aes_block <= j0;
                        aes_next  <= 1'b1;
                    end
                    CTR: begin
                        aes_block <= ctr_block;
                        aes_next  <= 1'b1;
                        ctr_next  <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (state != IDLE && (key_load || (start && owner == TM))) begin
                stale <= 1'b1;
            end

            if (complete) begin
                owner <= NONE;
                stale <= 1'b0;
                if (!discard) begin
                    case (owner)
                        KEY: key_pend <= 1'b0;
                        H: begin
                            h_pend  <= 1'b0;
                            h_data  <= aes_result;
                            h_ready <= 1'b1;
                        end
                        TM: begin
                            tm_pend       <= 1'b0;
                            tagmask_data  <= aes_result;
                            tagmask_valid <= 1'b1;
                        end
                        CTR: begin
                            ks_pend  <= 1'b0;
                            ks_data  <= aes_result;
                            ks_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

`ifdef AES_CORE_ARBITER_WDOG_EN
            if (wdog_fire) begin
                owner         <= NONE;
                stale         <= 1'b0;
                key_pend      <= 1'b0;
                h_pend        <= 1'b0;
                tm_pend       <= 1'b0;
                ks_pend       <= 1'b0;
                h_ready       <= 1'b0;
                tagmask_valid <= 1'b0;
            end
`endif

            // New requests are applied last so they override any clear above.
            if (key_load) begin
                key_pend      <= 1'b1;
                h_pend        <= 1'b1;
                tm_pend       <= 1'b0;
                ks_pend       <= 1'b0;
                h_ready       <= 1'b0;
                tagmask_valid <= 1'b0;
            end
            if (start) begin
                tm_pend       <= 1'b1;
                j0            <= {iv, J0_SUFFIX};
                tagmask_valid <= 1'b0;
            end
            if (ks_req && !key_load) ks_pend <= 1'b1;
        end
    end

`ifdef AES_CORE_ARBITER_WDOG_EN
    always_ff @(posedge clk) begin
        if (rst)            wdog_err <= 1'b0;
        else if (wdog_fire) wdog_err <= 1'b1;
    end
`else
    assign wdog_err = 1'b0;
`endif

endmodule
